// File: rtl/adder_4_fm_pkg.sv
// Shared types and helpers for the adder_4 formal-wrapper
// stimulus source and result checker.
package adder_4_fm_pkg;

  localparam int VEC_W       = 9;
  localparam int RES_W       = 5;
  localparam int NUM_VECTORS = 512;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [VEC_W-1:0] vec;
    logic [RES_W-1:0] gold;
  } dl_t;

  // vec = {a[3:0], b[3:0], cin}
  function automatic logic [RES_W-1:0] golden_add(
    input logic [VEC_W-1:0] vec
  );
    return {1'b0, vec[8:5]}
         + {1'b0, vec[4:1]}
         + {4'b0, vec[0]};
  endfunction

endpackage

// File: rtl/adder_4_fm_stimulus_checker_delay.sv
// Shift register that carries {valid, vec, golden} alongside
// the DUT pipeline; depth 0 is a straight pass-through.
module fm_delay_line
  import adder_4_fm_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  dl_t  din,
  output dl_t  dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign dout = din;
    end else begin : g_sr
      dl_t sr [DEPTH];

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          for (int i = 0; i < DEPTH; i++)
            sr[i] <= '0;
        end else begin
          sr[0] <= din;
          for (int i = 1; i < DEPTH; i++)
            sr[i] <= sr[i-1];
        end
      end

      assign dout = sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/adder_4_fm_stimulus_checker.sv
// Exhaustive 512-vector sweep of the adder_4 wrapper with
// latency-aligned golden compare and first-failure capture.
module adder_4_fm_stimulus_checker
  import adder_4_fm_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  output logic [3:0] stim_a,
  output logic [3:0] stim_b,
  output logic       stim_cin,
  input  logic [3:0] dut_sum,
  input  logic       dut_cout,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [9:0] err_count,
  output logic [8:0] first_fail_vec,
  output logic [4:0] first_fail_got
);

  localparam logic [2:0] DRAIN_LAST =
    3'(LATENCY > 0 ? LATENCY - 1 : 0);

  state_t           state;
  state_t           state_nxt;
  logic [VEC_W-1:0] vec;
  logic [2:0]       drain_cnt;
  logic [9:0]       err_q;
  logic [8:0]       ffv_q;
  logic [4:0]       ffg_q;

  dl_t              push;
  dl_t              tap;
  logic [RES_W-1:0] got;
  logic             mismatch;
  logic             start_ok;
  logic             last_vec;
  logic             drain_end;

  assign start_ok  = start
                   && (state == IDLE || state == DONE);
  assign last_vec  = vec == 9'(NUM_VECTORS - 1);
  assign drain_end = drain_cnt == DRAIN_LAST;

  always_ff @(posedge clk) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE:
        if (start) state_nxt = RUN;
      RUN:
        if (last_vec)
          state_nxt = (LATENCY == 0) ? DONE : DRAIN;
      DRAIN:
        if (drain_end) state_nxt = DONE;
      default:
        state_nxt = IDLE;
    endcase
  end

  always_comb begin
    push       = '0;
    push.valid = state == RUN;
    push.vec   = vec;
    push.gold  = golden_add(vec);
  end

  fm_delay_line #(
    .DEPTH (LATENCY)
  ) u_delay (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (push),
    .dout    (tap)
  );

  assign got      = {dut_cout, dut_sum};
  assign mismatch = tap.valid && (got != tap.gold);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vec       <= '0;
      drain_cnt <= '0;
      err_q     <= '0;
      ffv_q     <= '0;
      ffg_q     <= '0;
    end else if (start_ok) begin
      vec       <= '0;
      drain_cnt <= '0;
      err_q     <= '0;
      ffv_q     <= '0;
      ffg_q     <= '0;
    end else begin
      if (state == RUN && !last_vec)
        vec <= vec + 9'd1;
      if (state == DRAIN)
        drain_cnt <= drain_cnt + 3'd1;
      else
        drain_cnt <= '0;
      // Only the first mismatch of a sweep is captured
      if (mismatch) begin
        err_q <= err_q + 10'd1;
        if (err_q == '0) begin
          ffv_q <= tap.vec;
          ffg_q <= got;
        end
      end
    end
  end

  assign stim_a         = vec[8:5];
  assign stim_b         = vec[4:1];
  assign stim_cin       = vec[0];
  assign busy           = state == RUN
                       || state == DRAIN;
  assign done           = state == DONE;
  assign pass           = done && (err_q == '0);
  assign err_count      = err_q;
  assign first_fail_vec = ffv_q;
  assign first_fail_got = ffg_q;

endmodule

// File: doc/adder_4_fm_stimulus_checker.md
# adder_4_fm_stimulus_checker

Self-checking exhaustive stimulus source and result checker for the adder_4 formal-verification wrapper of the pre-configured FPGA fabric. It drives all 512 combinations of `{a[3:0], b[3:0], cin}` into the wrapper's benchmark input pins. It samples `{cout, sum[3:0]}` from the wrapper outputs after a fixed latency and compares them against an internal golden adder. It reports pass/fail, the error count and the first failing vector.

## Interface
Parameters:
- `LATENCY`, default 2: cycles from driving a vector to sampling its result. Legal range 0..4.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `reset_n`  in  1: synchronous, active-low reset.
- `start`  in  1: one-cycle pulse that begins a sweep. Honoured only in IDLE or DONE.
- `stim_a`  out  4: drives `a_3__fm..a_0__fm`.
- `stim_b`  out  4: drives `b_3__fm..b_0__fm`.
- `stim_cin`  out  1: drives `cin_fm`.
- `dut_sum`  in  4: from `out_sum_3__fm..out_sum_0__fm`.
- `dut_cout`  in  1: from `out_cout_fm`.
- `busy`  out  1: high in RUN and DRAIN.
- `done`  out  1: high in DONE. Sticky until the next `start` or reset.
- `pass`  out  1: `done && err_count == 0`.
- `err_count`  out  10: number of mismatching vectors, 0..512. Cannot overflow.
- `first_fail_vec`  out  9: vector index of the first mismatch.
- `first_fail_got`  out  5: `{dut_cout, dut_sum}` observed at the first mismatch.

## Operation
- Vector index `vec[8:0]` is split as `a = vec[8:5]`, `b = vec[4:1]`, `cin = vec[0]`.
- Golden result is the 5-bit value `{cout, sum} = a + b + cin`.
- FSM states:
  - IDLE: entered on reset. On `start`, clear `err_count`, `first_fail_*` and `vec`, then go to RUN.
  - RUN: drive `vec` and push `{golden, valid=1}` into the delay line. If `vec == 511`, go to DRAIN (or to DONE if `LATENCY == 0`). Otherwise increment `vec`.
  - DRAIN: stimulus is held at vector 511 and pushes carry `valid=0`. Stay `LATENCY` cycles, then go to DONE.
  - DONE: hold results. On `start`, behave as in IDLE.
- Compare: each cycle where the delay-line output is valid, compare `{dut_cout, dut_sum}` with the delayed golden result.
  - On mismatch, increment `err_count`.
  - If `err_count` was 0, also capture `first_fail_vec` (the delayed index) and `first_fail_got`.
- `start` while busy is ignored.
- `reset_n` low at any time takes effect on the next edge: back to IDLE, every output 0, delay line cleared.
- Reset value of every output is 0. This includes stimulus, so the DUT sees all-zero inputs in IDLE and after reset.

## Timing
- Rising edge with `start` in IDLE leads to RUN on the next cycle. Vector 0 appears on `stim_*` in the first RUN cycle.
- A vector driven in cycle t is compared in cycle t+LATENCY.
  - The DUT path must be purely combinational plus `LATENCY` registers.
  - With `LATENCY == 0`, the compare is combinational within the same cycle.
- Sweep length: 512 RUN cycles plus `LATENCY` DRAIN cycles. `done` rises in cycle 512+LATENCY counted from the first RUN cycle (cycle 0).
- `err_count` and `first_fail_*` update in the cycle after the compare. They are final when `done` rises.
- `busy` and `done` are never high together. `pass` is only ever high while `done` is high.

## Structure
- Package `adder_4_fm_pkg` holds:
  - FSM state enum (IDLE, RUN, DRAIN, DONE);
  - `VEC_W = 9`, `RES_W = 5`, `NUM_VECTORS = 512`;
  - a pure function `golden_add(vec)` returning 5 bits.
- One sub-module, `fm_delay_line`: a parameterised-depth shift register of `{valid, vec, golden}`.
  - Depth 0 is a pass-through.
  - Synchronous clear on `reset_n` low.
- The top of this block instantiates the FSM and counters, one `fm_delay_line`, and the compare/capture logic.

## Test plan
- Ideal adder model with 2-register delay, `LATENCY = 2`, pulse `start` → `done` rises 514 cycles after the first RUN cycle; `pass = 1`; `err_count = 0`.
- Same model with `dut_cout` stuck at 0 → `err_count = 256`; `first_fail_vec = 9'h01F` (a=0, b=15, cin=1); `first_fail_got = 5'h00`; `pass = 0`.
- DUT with 3-register delay, `LATENCY = 2` → `pass = 0`; `first_fail_vec = 9'h001`; `first_fail_got = 5'h00`.
- `LATENCY = 0` with a combinational ideal adder → `done` rises 512 cycles after the first RUN cycle; `pass = 1`.
- `reset_n` low at vector 100 → next cycle: IDLE; `busy`, `done`, `err_count` and all `stim_*` are 0. Then pulse `start` → a full sweep still passes.
- `start` pulsed mid-RUN → ignored, `vec` sequence is uninterrupted. `start` in DONE after a failing run → `err_count` and `first_fail_*` clear, `done` falls, vector 0 is re-driven.
